imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time controller that fills the 32-word instruction memory of the instruction fetch stage through its load port (`load_mem_en`/`load_mem_addr`/`load_mem_data`). It accepts a byte stream from a host link (e.g. UART receiver) over a valid/ready handshake and packs four bytes per word, little-endian. It writes words to consecutive addresses starting at 0. The core is held stalled until the programmed number of words has been written.

## Interface
- `DEPTH`, 32, instruction memory depth in words.
- `ADDR_W`, 5, load address width; `2**ADDR_W == DEPTH`.

- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: one-cycle pulse; begins a load when in IDLE or DONE.
- `word_count` input 6: number of words to load, sampled on accepted `start`.
- `in_valid` input 1: host byte valid.
- `in_data` input 8: host byte.
- `in_ready` output 1: loader accepts a byte this cycle.
- `load_mem_en` output 1: one-cycle write strobe to the instruction memory.
- `load_mem_addr` output ADDR_W: write word address.
- `load_mem_data` output 32: write word.
- `core_hold` output 1: drives the fetch stage `stall`; high keeps the PC frozen.
- `busy` output 1: a load is in progress.
- `done` output 1: level; last load completed successfully.
- `err` output 1: level; last load failed the checksum (macro builds only).

## Operation
- FSM states: IDLE, LOAD, CHECK (macro builds only), DONE.
- Reset (async, `rst_n` low) forces the following register values:
  - state = IDLE, `core_hold` = 1, `in_ready` = 0, `load_mem_en` = 0, `load_mem_addr` = 0, `load_mem_data` = 0, `busy` = 0, `done` = 0, `err` = 0.
  - Byte counter = 0, word counter = 0, checksum = 0.
- IDLE/DONE + `start`:
  - Latch the effective count: `word_count` 0 or >DEPTH is treated as DEPTH.
  - Clear the counters, checksum, `done` and `err`; set `core_hold` = 1 and `busy` = 1; go to LOAD.
- LOAD:
  - `in_ready` = 1.
  - Each handshake (`in_valid & in_ready`) stores `in_data` in byte lane `byte_cnt` (lane 0 = bits 7:0) and adds it mod 256 to the checksum.
  - On the 4th byte, the assembled word is written at address = word counter, and the word counter increments.
  - After the last word's 4th byte: go to CHECK (macro builds) or DONE.
- CHECK: `in_ready` = 1; the next accepted byte is compared with the checksum.
  - Equal → DONE.
  - Unequal → IDLE with `err` = 1 and `core_hold` left at 1.
- DONE: `done` = 1, `busy` = 0, `core_hold` = 0; the core runs from PC 0.
- `start` while in LOAD or CHECK is ignored.
- `in_valid` outside LOAD/CHECK is ignored (`in_ready` = 0, no byte consumed).
- Address never wraps: at most DEPTH writes per load; the word counter is 6 bits wide internally.
- Reset mid-load aborts immediately. Memory words already written keep their contents; `core_hold` returns to 1.

## Timing
- Write latency: `load_mem_en` is high for exactly one cycle, the cycle after the handshake of a word's 4th byte. Address and data are registered and valid in that same cycle.
- Throughput: one byte per cycle. `in_ready` never deasserts inside LOAD, including during the write-strobe cycle.
- LOAD→DONE: the transition takes effect on the edge after the final byte is accepted (the final checksum byte in macro builds, the final data byte otherwise).
  - Without the macro, `done` rises in the same cycle as the last `load_mem_en`.
  - `core_hold` falls in the same cycle `done` rises.
- `start` accepted in cycle N: `busy` = 1 and `in_ready` = 1 from cycle N+1.
- `start` coinciding with `in_valid`: the byte in that cycle is not consumed.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined:
  - The CHECK state exists, and the stream carries one trailing checksum byte equal to the 8-bit sum of all data bytes.
  - A mismatch sets `err` and keeps the core held.
- Not defined:
  - No CHECK state; LOAD goes directly to DONE.
  - `err` is tied to 0 and no trailing byte is consumed.

## Test plan
- Reset: assert `rst_n`=0 mid-LOAD after 2 words → all outputs at reset values, `core_hold`=1; memory words 0–1 retain their values.
- Basic load:
  - Stimulus: `start` with `word_count`=2, bytes 78 56 34 12 EF BE AD DE streamed back-to-back.
  - Response: writes 0x12345678 @0, then 0xDEADBEEF @1, each a single-cycle strobe; then `done`=1 and `core_hold`=0.
- Clamp and stalls:
  - Stimulus: `word_count`=0; 128 bytes with random `in_valid` gaps.
  - Response: exactly 32 writes at addresses 0..31; no write at address wrap-around.
- Ignored inputs:
  - Stimulus: `start` pulsed during LOAD; `in_valid` held high in IDLE.
  - Response: no restart and no byte consumed; the counters are unchanged.
- Checksum (macro on):
  - Stimulus: `word_count`=1, bytes 01 02 03 04, checksum byte 0x0A.
  - Response: `done`=1. Repeating with checksum 0x0B gives `err`=1, `done`=0, `core_hold`=1.
- Reload: `start` from DONE → `core_hold` returns to 1 in the next cycle; a new load overwrites from address 0.

Source files
------------

// File: rtl/imem_loader.sv
// Boot loader: packs a little-endian host byte stream into 32-bit words and writes them to
// the instruction memory load port while holding the core. IMEM_LOADER_CHECKSUM_EN adds a trailing checksum byte.
module imem_loader #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [5:0]        i_word_count,
  input  logic              i_in_valid,
  input  logic [7:0]        i_in_data,
  output logic              o_in_ready,
  output logic              o_load_mem_en,
  output logic [ADDR_W-1:0] o_load_mem_addr,
  output logic [31:0]       o_load_mem_data,
  output logic              o_core_hold,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CHECK, S_DONE} state_t;

  localparam logic [5:0] DEPTH_W = 6'(DEPTH);

  state_t              r_state;
  state_t              w_next;
  logic [1:0]          r_byte_cnt;
  logic [5:0]          r_word_cnt;
  logic [5:0]          r_count;
  logic [23:0]         r_buf;
  logic                r_load_en;
  logic [ADDR_W-1:0]   r_load_addr;
  logic [31:0]         r_load_data;

  logic                w_in_ready;
  logic                w_hs;
  logic                w_start;
  logic                w_last_byte;
  logic [5:0]          w_eff_count;

  assign w_in_ready  = (r_state == S_LOAD) || (r_state == S_CHECK);
  assign w_hs        = i_in_valid & w_in_ready;
  assign w_start     = i_start & ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last_byte = (r_state == S_LOAD) && w_hs && (r_byte_cnt == 2'd3) &&
                       (r_word_cnt == r_count - 6'd1);
  // Zero or oversize requests fill the whole memory rather than wrapping the address.
  assign w_eff_count = ((i_word_count == 6'd0) || (i_word_count > DEPTH_W)) ? DEPTH_W : i_word_count;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] r_sum;
  logic       r_err;
  logic       w_sum_ok;
  assign w_sum_ok = (i_in_data == r_sum);
  assign o_err    = r_err;
`else
  assign o_err    = 1'b0;
`endif

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (w_start) w_next = S_LOAD;
      S_LOAD: begin
        if (w_last_byte) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          w_next = S_CHECK;
`else
          w_next = S_DONE;
`endif
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHECK: if (w_hs) w_next = w_sum_ok ? S_DONE : S_IDLE;
`endif
      default: w_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    o_in_ready  = w_in_ready;
    o_busy      = w_in_ready;
    o_done      = (r_state == S_DONE);
    o_core_hold = (r_state != S_DONE);
  end

  assign o_load_mem_en   = r_load_en;
  assign o_load_mem_addr = r_load_addr;
  assign o_load_mem_data = r_load_data;

  // Byte packing, word counter and the registered write port
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_byte_cnt  <= '0;
      r_word_cnt  <= '0;
      r_count     <= '0;
      r_buf       <= '0;
      r_load_en   <= 1'b0;
      r_load_addr <= '0;
      r_load_data <= '0;
    end else begin
      r_load_en <= 1'b0;
      if (w_start) begin
        r_byte_cnt <= '0;
        r_word_cnt <= '0;
        r_count    <= w_eff_count;
      end else if ((r_state == S_LOAD) && w_hs) begin
        r_byte_cnt <= r_byte_cnt + 2'd1;
        if (r_byte_cnt == 2'd3) begin
          r_load_en   <= 1'b1;
          r_load_addr <= r_word_cnt[ADDR_W-1:0];
          r_load_data <= {i_in_data, r_buf};
          r_word_cnt  <= r_word_cnt + 6'd1;
        end else begin
          r_buf[{r_byte_cnt, 3'b000} +: 8] <= i_in_data;
        end
      end
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sum <= '0;
      r_err <= 1'b0;
    end else if (w_start) begin
      r_sum <= '0;
      r_err <= 1'b0;
    end else if ((r_state == S_LOAD) && w_hs) begin
      r_sum <= r_sum + i_in_data;
    end else if ((r_state == S_CHECK) && w_hs && !w_sum_ok) begin
      r_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: a phase/byte-count reference model is compared with the
// DUT on every negedge; literal expectations pin the directed scenarios.
module tb_imem_loader;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  wc = '0;
  logic        valid = 1'b0;
  logic [7:0]  din = '0;
  logic        o_in_ready, o_load_mem_en, o_core_hold, o_busy, o_done, o_err;
  logic [4:0]  o_load_mem_addr;
  logic [31:0] o_load_mem_data;

  imem_loader #(.DEPTH(32), .ADDR_W(5)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_word_count(wc),
    .i_in_valid(valid), .i_in_data(din), .o_in_ready(o_in_ready),
    .o_load_mem_en(o_load_mem_en), .o_load_mem_addr(o_load_mem_addr),
    .o_load_mem_data(o_load_mem_data), .o_core_hold(o_core_hold),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err));

  always #5 clk = ~clk;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  int n_chk = 0, n_err = 0, n_wr = 0;
  logic [31:0] dmem [32];
  logic [31:0] mmem [32];

  // Model: phase 0 idle, 1 load, 2 check, 3 done; data bytes counted over the whole load.
  int          m_phase = 0, m_total = 0, m_nb = 0;
  logic [7:0]  m_sum = '0;
  logic [31:0] m_word = '0;
  bit          m_pend = 1'b0, m_err = 1'b0;
  logic [4:0]  m_addr = '0;
  logic [31:0] m_data = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      if (n_err < 40) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      m_phase = 0; m_nb = 0; m_sum = '0; m_pend = 1'b0; m_err = 1'b0;
      m_addr = '0; m_data = '0; m_total = 0;
    end
    chk("in_ready",  32'(o_in_ready),  32'(m_phase == 1 || m_phase == 2));
    chk("busy",      32'(o_busy),      32'(m_phase == 1 || m_phase == 2));
    chk("done",      32'(o_done),      32'(m_phase == 3));
    chk("core_hold", 32'(o_core_hold), 32'(m_phase != 3));
    chk("err",       32'(o_err),       32'(m_err));
    chk("mem_en",    32'(o_load_mem_en), 32'(m_pend));
    chk("mem_addr",  32'(o_load_mem_addr), 32'(m_addr));
    chk("mem_data",  o_load_mem_data, m_data);
    if (o_load_mem_en === 1'b1) begin dmem[o_load_mem_addr] = o_load_mem_data; n_wr++; end
    if (m_pend) mmem[m_addr] = m_data;
    if (rst_n) begin
      m_pend = 1'b0;
      if ((m_phase == 0 || m_phase == 3) && start) begin
        m_total = (wc == 0 || wc > 32) ? 32 : int'(wc);
        m_nb = 0; m_sum = '0; m_err = 1'b0; m_phase = 1;
      end else if (m_phase == 1 && valid) begin
        m_word[(m_nb % 4) * 8 +: 8] = din;
        m_sum = m_sum + din;
        m_nb++;
        if (m_nb % 4 == 0) begin
          m_pend = 1'b1; m_addr = 5'(m_nb / 4 - 1); m_data = m_word;
        end
        if (m_nb == m_total * 4) m_phase = CK ? 2 : 3;
      end else if (m_phase == 2 && valid) begin
        if (din == m_sum) m_phase = 3;
        else begin m_phase = 0; m_err = 1'b1; end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit got = 1'b0;
    bit rdy;
    valid = 1'b0;
    repeat (gap) step();
    valid = 1'b1; din = b;
    for (int t = 0; t < 50 && !got; t++) begin
      @(negedge clk); rdy = o_in_ready; step();
      if (rdy) got = 1'b1;
    end
    if (!got) begin
      n_chk++; n_err++;
      $display("FAIL handshake_timeout: got ready=0 expected ready=1 for byte %h", b);
    end
  endtask

  task automatic do_start(input logic [5:0] w, input bit junk);
    start = 1'b1; wc = w; valid = junk; din = 8'hFF;
    step();
    start = 1'b0; valid = 1'b0;
  endtask

  // Streams a byte list (plus trailing checksum in checksum builds) with random gaps.
  task automatic send_q(input logic [7:0] q[$], input int gapmax, input bit bad_ck);
    logic [7:0] s = '0;
    foreach (q[i]) begin
      s = s + q[i];
      send_byte(q[i], $urandom_range(0, gapmax));
    end
    if (CK) send_byte(bad_ck ? s + 8'd1 : s, $urandom_range(0, gapmax));
    valid = 1'b0;
    repeat (3) step();
  endtask

  function automatic void rand_q(output logic [7:0] q[$], input int n);
    q = {};
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
  endfunction

  initial begin
    logic [7:0] q[$];
    int wr0, nw;
    for (int i = 0; i < 32; i++) begin dmem[i] = 32'hA5A5_A5A5; mmem[i] = 32'hA5A5_A5A5; end
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    chk("reset_hold", 32'(o_core_hold), 32'd1);
    chk("reset_busy", 32'(o_busy), 32'd0);

    // Basic load; the byte offered with start must not be consumed.
    do_start(6'd2, 1'b1);
    q = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send_q(q, 0, 1'b0);
    chk("basic_w0", dmem[0], 32'h1234_5678);
    chk("basic_w1", dmem[1], 32'hDEAD_BEEF);
    chk("basic_done", 32'(o_done), 32'd1);
    chk("basic_hold", 32'(o_core_hold), 32'd0);

    // in_valid held high while DONE is ignored.
    valid = 1'b1; din = 8'h5A;
    repeat (4) step();
    valid = 1'b0;

    // Reload from DONE with a start pulse in the middle of LOAD.
    wr0 = n_wr;
    do_start(6'd3, 1'b0);
    chk("reload_hold", 32'(o_core_hold), 32'd1);
    rand_q(q, 12);
    for (int i = 0; i < 5; i++) send_byte(q[i], 0);
    start = 1'b1; wc = 6'd7;
    send_byte(q[5], 0);
    start = 1'b0;
    send_q(q[6:11], 1, 1'b0);
    chk("reload_writes", 32'(n_wr - wr0), 32'd3);
    chk("reload_w0", dmem[0], {q[3], q[2], q[1], q[0]});

    // Clamp: zero and oversize counts both fill exactly 32 words.
    for (int k = 0; k < 2; k++) begin
      wr0 = n_wr;
      do_start(k == 0 ? 6'd0 : 6'd45, 1'b0);
      rand_q(q, 128);
      send_q(q, 3, 1'b0);
      chk("clamp_writes", 32'(n_wr - wr0), 32'd32);
      valid = 1'b1; din = 8'h33;
      repeat (3) step();
      valid = 1'b0;
    end

    // Random short loads.
    for (int k = 0; k < 4; k++) begin
      nw = $urandom_range(1, 6);
      do_start(6'(nw), 1'($urandom));
      rand_q(q, nw * 4);
      send_q(q, 2, 1'b0);
    end

    // Checksum scenario (plain done/data check in the default build).
    do_start(6'd1, 1'b0);
    send_q('{8'h01, 8'h02, 8'h03, 8'h04}, 0, 1'b0);
    chk("ck_done", 32'(o_done), 32'd1);
    chk("ck_w0", dmem[0], 32'h0403_0201);
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk("ck_err_clear", 32'(o_err), 32'd0);
    do_start(6'd1, 1'b0);
    send_q('{8'h01, 8'h02, 8'h03, 8'h04}, 0, 1'b1);
    chk("ckbad_err", 32'(o_err), 32'd1);
    chk("ckbad_done", 32'(o_done), 32'd0);
    chk("ckbad_hold", 32'(o_core_hold), 32'd1);
`endif

    // Reset mid-load after two words.
    do_start(6'd4, 1'b0);
    rand_q(q, 10);
    for (int i = 0; i < 10; i++) send_byte(q[i], 0);
    valid = 1'b0;
    repeat (2) step();
    rst_n = 1'b0;
    step();
    chk("rst_hold", 32'(o_core_hold), 32'd1);
    chk("rst_en", 32'(o_load_mem_en), 32'd0);
    chk("rst_data", o_load_mem_data, 32'd0);
    chk("rst_keep_w0", dmem[0], {q[3], q[2], q[1], q[0]});
    chk("rst_keep_w1", dmem[1], {q[7], q[6], q[5], q[4]});
    rst_n = 1'b1;
    step();

    // in_valid held in IDLE, then a fresh load starts from address 0.
    valid = 1'b1; din = 8'hC3;
    repeat (5) step();
    valid = 1'b0;
    wr0 = n_wr;
    do_start(6'd1, 1'b0);
    send_q('{8'h11, 8'h22, 8'h33, 8'h44}, 0, 1'b0);
    chk("idle_w0", dmem[0], 32'h4433_2211);
    chk("idle_writes", 32'(n_wr - wr0), 32'd1);

    for (int i = 0; i < 32; i++) chk("mem_image", dmem[i], mmem[i]);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
